alsu_seq: RTL and testbench
===========================

ALSU_SEQ -- requirements
Module: alsu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16, datapath width in bits (legal: 8..64, power of two).
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), shift-amount field width; not overridden by users.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port in_valid  input  1  operand/opcode presented.
REQ-006 SHALL have port in_ready  output  1  block can accept an operation.
REQ-007 SHALL have port FUNC  input  3  opcode (0 ADD, 1 SUB, 2 SHL, 3 SHR, 4 AND, 5 XOR, 6 NOT, 7 INC).
REQ-008 SHALL have ports a, b  input  WIDTH  operands.
REQ-009 SHALL have port out_valid  output  1  result and flags valid.
REQ-010 SHALL have port out_ready  input  1  consumer takes result.
REQ-011 SHALL have port r  output  WIDTH  registered result.
REQ-012 SHALL have ports z, n, c  output  1 each  zero, negative, carry/borrow flags, registered with r.

Function
REQ-013 SHALL accept an operation at a rising edge where in_valid && in_ready; a, b, FUNC are sampled only then.
REQ-014 SHALL drive in_ready = 1 only in state IDLE; no overlap of operations.
REQ-015 SHALL implement states IDLE, SHIFT, DONE: IDLE->DONE on accept of non-shift op or shift with amount 0; IDLE->SHIFT on accept of shift with amount k>=1; SHIFT->DONE when k single-bit shifts done; DONE->IDLE on out_valid && out_ready.
REQ-016 SHALL use shift amount k = b[SHW-1:0]; upper bits of b ignored for SHL/SHR.
REQ-017 SHALL perform shifts one bit per cycle; out_valid rises after the (k+1)th rising edge counted from the acceptance edge inclusive; single-cycle ops and k=0 after the acceptance edge itself.
REQ-018 SHALL compute: ADD r=a+b, c=carry out; SUB r=a-b mod 2^WIDTH, c=1 iff a<b unsigned; INC r=a+1, c=carry out.
REQ-019 SHALL compute SHL/SHR logical (zero fill), c = last bit shifted out, c=0 when k=0.
REQ-020 SHALL compute AND r=a&b, XOR r=a^b, NOT r=~a; c=0 for all three.
REQ-021 SHALL set z = (r==0) and n = r[WIDTH-1] for every opcode.
REQ-022 SHALL hold out_valid, r, z, n, c stable in DONE while out_ready=0.
REQ-023 SHALL keep r, z, n, c at last completed value while IDLE or SHIFT; out_valid=0 outside DONE.
REQ-024 SHALL ignore in_valid while not IDLE; a simultaneous out_ready handshake and new in_valid is accepted only on the following edge (IDLE first).

Reset
REQ-025 SHALL, on rst_n=0 at any time including mid-SHIFT, asynchronously force state IDLE, out_valid=0, r=0, z=0, n=0, c=0, shift counter 0, and abandon the operation.
REQ-026 SHALL drive in_ready=1 in the first cycle after rst_n deasserts.

Structure
REQ-027 SHALL take opcode encodings and state encoding from shared package alsu_pkg.
REQ-028 SHALL place single-cycle ops (ADD, SUB, AND, XOR, NOT, INC, flag generation) in combinational sub-module alsu_core parametrised by WIDTH; shift sequencing and FSM stay in alsu_seq.
REQ-029 SHALL be synthesisable, no latches, no combinational path from in_valid to in_ready.

Verification (WIDTH=16 unless noted)
REQ-030 SHALL cover: a=3, b=10, FUNC=0 -> r=13, z=0, n=0, c=0, out_valid one edge after accept.
REQ-031 SHALL cover: a=3, b=10, FUNC=1 -> r=0xFFF9, n=1, c=1, z=0.
REQ-032 SHALL cover: a=0x8003, b=4, FUNC=2 -> in_ready=0 during SHIFT, out_valid after 5th edge, r=0x0030, c=0; then b=0x0011, FUNC=3 on a=0x0003 -> k=1, r=0x0001, c=1.
REQ-033 SHALL cover: FUNC=6 a=3 with out_ready=0 for 4 cycles -> r=0xFFFC, n=1 held stable, in_ready=0, new in_valid ignored until handshake.
REQ-034 SHALL cover: rst_n pulled low mid-SHIFT (a=1, b=15) -> out_valid=0, r=0, flags 0 immediately; in_ready=1 next cycle after release.
REQ-035 SHALL cover WIDTH=8: a=0xFF, FUNC=7 -> r=0x00, z=1, c=1, n=0.

Source files
------------

// File: rtl/alsu_pkg.sv
// Shared opcode and FSM state encodings for the sequential ALU/shifter.
package alsu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_SHL = 3'd2,
    OP_SHR = 3'd3,
    OP_AND = 3'd4,
    OP_XOR = 3'd5,
    OP_NOT = 3'd6,
    OP_INC = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic logic is_shift(input op_e op);
    return (op == OP_SHL) || (op == OP_SHR);
  endfunction

endpackage

// File: rtl/alsu_core.sv
// Combinational single-cycle datapath: arithmetic/logic result plus z/n/c flags.
module alsu_core
  import alsu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] r,
  output logic             z,
  output logic             n,
  output logic             c
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum = '0;
    r   = '0;
    c   = 1'b0;
    case (op)
      OP_ADD: begin
        sum = {1'b0, a} + {1'b0, b};
        r   = sum[WIDTH-1:0];
        c   = sum[WIDTH];
      end
      OP_SUB: begin
        r = a - b;
        c = (a < b);
      end
      OP_INC: begin
        sum = {1'b0, a} + (WIDTH+1)'(1);
        r   = sum[WIDTH-1:0];
        c   = sum[WIDTH];
      end
      OP_AND:  r = a & b;
      OP_XOR:  r = a ^ b;
      OP_NOT:  r = ~a;
      // shifts pass a through so a zero-amount shift completes here with c=0
      default: r = a;
    endcase
  end

  assign z = (r == '0);
  assign n = r[WIDTH-1];

endmodule

// File: rtl/alsu_seq.sv
// Sequential ALU: single-cycle ops via alsu_core, bit-serial logical shifts,
// valid/ready handshake on both sides.
module alsu_seq
  import alsu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       FUNC,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r,
  output logic             z,
  output logic             n,
  output logic             c
);

  state_e           state;
  op_e              op;
  logic [SHW-1:0]   k;
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] sh_nxt;
  logic             sh_out;
  logic             dir_left;
  logic [WIDTH-1:0] core_r;
  logic             core_z;
  logic             core_n;
  logic             core_c;

  assign op = op_e'(FUNC);
  assign k  = b[SHW-1:0];

  alsu_core #(.WIDTH(WIDTH)) u_core (
    .op (op),
    .a  (a),
    .b  (b),
    .r  (core_r),
    .z  (core_z),
    .n  (core_n),
    .c  (core_c)
  );

  always_comb begin
    sh_nxt = '0;
    sh_out = 1'b0;
    if (dir_left) begin
      sh_nxt = {sh[WIDTH-2:0], 1'b0};
      sh_out = sh[WIDTH-1];
    end else begin
      sh_nxt = {1'b0, sh[WIDTH-1:1]};
      sh_out = sh[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      r         <= '0;
      z         <= 1'b0;
      n         <= 1'b0;
      c         <= 1'b0;
      sh        <= '0;
      cnt       <= '0;
      dir_left  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            if (is_shift(op) && (k != '0)) begin
              sh       <= a;
              cnt      <= k;
              dir_left <= (op == OP_SHL);
              state    <= SHIFT;
            end else begin
              r         <= core_r;
              z         <= core_z;
              n         <= core_n;
              c         <= core_c;
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        SHIFT: begin
          // working copy in sh keeps r at the previous result until the last step
          sh  <= sh_nxt;
          cnt <= cnt - SHW'(1);
          if (cnt == SHW'(1)) begin
            r         <= sh_nxt;
            z         <= (sh_nxt == '0);
            n         <= sh_nxt[WIDTH-1];
            c         <= sh_out;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alsu_seq.sv
// Bench for alsu_seq: directed table, handshake/reset sequences, random ops vs arithmetic model.
module tb_alsu_seq;

  typedef struct packed {
    logic [63:0] r;
    logic        z;
    logic        n;
    logic        c;
    logic [31:0] lat;
  } res_t;

  typedef struct packed {
    logic        w8;
    logic [2:0]  f;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] r;
    logic        z;
    logic        n;
    logic        c;
    logic [31:0] lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iv16, iv8, ir16, ir8, ov16, ov8, out_ready;
  logic [2:0]  func;
  logic [15:0] a, b, r16;
  logic [7:0]  r8;
  logic        z16, n16, c16, z8, n8, c8;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  alsu_seq dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .FUNC(func),
    .a(a), .b(b), .out_valid(ov16), .out_ready(out_ready),
    .r(r16), .z(z16), .n(n16), .c(c16)
  );

  alsu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .FUNC(func),
    .a(a[7:0]), .b(b[7:0]), .out_valid(ov8), .out_ready(out_ready),
    .r(r8), .z(z8), .n(n8), .c(c8)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic res_t model(input int w, input logic [2:0] f,
                                 input logic [63:0] aa, input logic [63:0] bb);
    res_t        res;
    logic [63:0] m, s;
    int          k;
    m = (64'd1 << w) - 64'd1;
    k = int'(bb[5:0]) & (w - 1);
    res = '0;
    res.lat = 1;
    case (f)
      3'd0: begin s = aa + bb; res.r = s & m; res.c = s[w]; end
      3'd1: begin res.r = (aa - bb) & m; res.c = (aa < bb); end
      3'd2: begin res.r = (aa << k) & m; res.c = (k != 0) ? aa[w-k] : 1'b0; res.lat = k + 1; end
      3'd3: begin res.r = aa >> k; res.c = (k != 0) ? aa[k-1] : 1'b0; res.lat = k + 1; end
      3'd4: res.r = aa & bb;
      3'd5: res.r = aa ^ bb;
      3'd6: res.r = ~aa & m;
      default: begin s = aa + 64'd1; res.r = s & m; res.c = s[w]; end
    endcase
    res.z = (res.r == 64'd0);
    res.n = res.r[w-1];
    return res;
  endfunction

  // Issue one op, measure edges from acceptance to out_valid, then complete the handshake.
  task automatic do_op(input logic w8, input logic [2:0] f, input logic [15:0] aa,
                       input logic [15:0] bb, output res_t got, output logic ir_low);
    int   waited;
    logic ov;
    got    = '0;
    ir_low = 1'b1;
    @(negedge clk);
    waited = 0;
    while (!(w8 ? ir8 : ir16) && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!(w8 ? ir8 : ir16)) begin
      chk("in_ready_timeout", 64'd0, 64'd1);
      return;
    end
    func = f; a = aa; b = bb; out_ready = 1'b0;
    if (w8) iv8 = 1'b1; else iv16 = 1'b1;
    @(posedge clk);
    #1;
    iv8 = 1'b0; iv16 = 1'b0;
    do begin
      @(negedge clk);
      got.lat++;
      ov = w8 ? ov8 : ov16;
      if (!ov && (w8 ? ir8 : ir16)) ir_low = 1'b0;
    end while (!ov && got.lat < 100);
    got.r = w8 ? {56'd0, r8} : {48'd0, r16};
    got.z = w8 ? z8 : z16;
    got.n = w8 ? n8 : n16;
    got.c = w8 ? c8 : c16;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[15];
    res_t        got, exp;
    logic        ir_low;
    logic [15:0] ra, rb;
    logic        w8;
    logic [2:0]  f;

    tbl[0]  = '{1'b0, 3'd0, 16'h0003, 16'h000A, 16'h000D, 1'b0, 1'b0, 1'b0, 32'd1};
    tbl[1]  = '{1'b0, 3'd1, 16'h0003, 16'h000A, 16'hFFF9, 1'b0, 1'b1, 1'b1, 32'd1};
    tbl[2]  = '{1'b0, 3'd2, 16'h8003, 16'h0004, 16'h0030, 1'b0, 1'b0, 1'b0, 32'd5};
    tbl[3]  = '{1'b0, 3'd3, 16'h0003, 16'h0011, 16'h0001, 1'b0, 1'b0, 1'b1, 32'd2};
    tbl[4]  = '{1'b0, 3'd4, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 1'b0, 1'b0, 32'd1};
    tbl[5]  = '{1'b0, 3'd5, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0, 32'd1};
    tbl[6]  = '{1'b0, 3'd7, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 32'd1};
    tbl[7]  = '{1'b0, 3'd0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b0, 1'b1, 32'd1};
    tbl[8]  = '{1'b0, 3'd3, 16'h8000, 16'h000F, 16'h0001, 1'b0, 1'b0, 1'b0, 32'd16};
    tbl[9]  = '{1'b0, 3'd2, 16'h0001, 16'h0010, 16'h0001, 1'b0, 1'b0, 1'b0, 32'd1};
    tbl[10] = '{1'b0, 3'd2, 16'h0001, 16'h000F, 16'h8000, 1'b0, 1'b1, 1'b0, 32'd16};
    tbl[11] = '{1'b0, 3'd1, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b0, 1'b0, 32'd1};
    tbl[12] = '{1'b0, 3'd6, 16'h0003, 16'h1234, 16'hFFFC, 1'b0, 1'b1, 1'b0, 32'd1};
    tbl[13] = '{1'b1, 3'd7, 16'h00FF, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 32'd1};
    tbl[14] = '{1'b1, 3'd2, 16'h0081, 16'h0009, 16'h0002, 1'b0, 1'b0, 1'b1, 32'd2};

    rst_n = 1'b0; iv16 = 1'b0; iv8 = 1'b0; out_ready = 1'b0;
    func = 3'd0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_state16", {ov16, ir16, r16, z16, n16, c16}, {1'b0, 1'b1, 16'h0000, 3'b000});
    chk("reset_state8", {ov8, ir8, r8, z8, n8, c8}, {1'b0, 1'b1, 8'h00, 3'b000});

    for (int i = 0; i < 15; i++) begin
      do_op(tbl[i].w8, tbl[i].f, tbl[i].a, tbl[i].b, got, ir_low);
      chk($sformatf("tbl%0d_r", i), got.r, {48'd0, tbl[i].r});
      chk($sformatf("tbl%0d_znc", i), {got.z, got.n, got.c}, {tbl[i].z, tbl[i].n, tbl[i].c});
      chk($sformatf("tbl%0d_latency", i), got.lat, tbl[i].lat);
      chk($sformatf("tbl%0d_busy", i), ir_low, 1'b1);
    end

    // NOT held in DONE while a new request waits; it is taken only after the handshake
    @(negedge clk);
    func = 3'd6; a = 16'h0003; b = 16'h0000; iv16 = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1;
    func = 3'd0; a = 16'h0001; b = 16'h0001;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("hold%0d", i), {ov16, ir16, n16, r16}, {1'b1, 1'b0, 1'b1, 16'hFFFC});
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("after_handshake", {ov16, ir16, r16}, {1'b0, 1'b1, 16'hFFFC});
    @(posedge clk);
    #1;
    iv16 = 1'b0;
    @(negedge clk);
    chk("queued_add", {ov16, r16, c16}, {1'b1, 16'h0002, 1'b0});
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;

    // reset asserted in the middle of a long shift
    @(negedge clk);
    func = 3'd2; a = 16'h0001; b = 16'h000F; iv16 = 1'b1;
    @(posedge clk);
    #1;
    iv16 = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_shift", {ov16, ir16, r16}, {1'b0, 1'b0, 16'h0002});
    rst_n = 1'b0;
    #1;
    chk("async_reset", {ov16, r16, z16, n16, c16}, {1'b0, 16'h0000, 3'b000});
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", {ir16, ov16}, {1'b1, 1'b0});
    do_op(1'b0, 3'd0, 16'h0003, 16'h000A, got, ir_low);
    chk("recover_add", {got.r[15:0], got.lat[3:0]}, {16'h000D, 4'd1});

    for (int i = 0; i < 150; i++) begin
      w8 = ($urandom_range(0, 3) == 0);
      f  = 3'($urandom_range(0, 7));
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (w8) begin
        ra = ra & 16'h00FF;
        rb = rb & 16'h00FF;
      end
      exp = model(w8 ? 8 : 16, f, {48'd0, ra}, {48'd0, rb});
      do_op(w8, f, ra, rb, got, ir_low);
      chk($sformatf("rnd%0d_w%0d_f%0d_r", i, w8 ? 8 : 16, f), got.r, exp.r);
      chk($sformatf("rnd%0d_znc", i), {got.z, got.n, got.c}, {exp.z, exp.n, exp.c});
      chk($sformatf("rnd%0d_latency", i), got.lat, exp.lat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
